// File: rtl/network_sched_pkg.sv
// Shared types and defaults for the transmit queue scheduler.
// Imported by the arbiter and the scheduler top level.
package network_sched_pkg;

    localparam int DEF_QUEUE_NUM  = 8;
    localparam int DEF_DESC_WIDTH = 57;
    localparam int DEF_QID_WIDTH  = 3;

    localparam logic SCHED_SP = 1'b0;
    localparam logic SCHED_RR = 1'b1;

    typedef enum logic [1:0] {
        IDLE_S   = 2'd0,
        OUTPUT_S = 2'd1,
        WAIT_S   = 2'd2
    } sched_state_e;

endpackage

// File: rtl/network_queue_scheduler_arbiter.sv
// Combinational queue picker: strict priority (highest index)
// or round robin starting at the pointer and wrapping upward.
module queue_select_arbiter
    import network_sched_pkg::*;
#(
    parameter int QUEUE_NUM = DEF_QUEUE_NUM,
    parameter int QID_WIDTH = DEF_QID_WIDTH
) (
    input  logic [QUEUE_NUM-1:0] elig_i,
    input  logic [QID_WIDTH-1:0] ptr_i,
    input  logic                 mode_i,
    output logic [QID_WIDTH-1:0] winner_o,
    output logic                 any_valid_o
);

    logic                 found;
    logic [QID_WIDTH-1:0] idx;

    always_comb begin
        winner_o    = '0;
        found       = 1'b0;
        idx         = '0;
        any_valid_o = |elig_i;
        if (mode_i == SCHED_SP) begin
            // ascending scan so the last hit is the highest index
            for (int i = 0; i < QUEUE_NUM; i++) begin
                if (elig_i[i]) begin
                    winner_o = QID_WIDTH'(i);
                end
            end
        end else begin
            for (int k = 0; k < QUEUE_NUM; k++) begin
                idx = QID_WIDTH'((int'(ptr_i) + k) % QUEUE_NUM);
                if (!found && elig_i[idx]) begin
                    winner_o = idx;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/network_queue_scheduler.sv
// Transmit descriptor scheduler: grants one eligible queue, reads one
// descriptor, issues it downstream, then waits for ready.
module network_queue_scheduler
    import network_sched_pkg::*;
#(
    parameter int QUEUE_NUM  = DEF_QUEUE_NUM,
    parameter int DESC_WIDTH = DEF_DESC_WIDTH,
    parameter int QID_WIDTH  = DEF_QID_WIDTH
) (
    input  logic                            i_clk,
    input  logic                            i_rst,
    input  logic [QUEUE_NUM-1:0]            iv_fifo_empty,
    output logic [QUEUE_NUM-1:0]            ov_fifo_rd,
    input  logic [QUEUE_NUM*DESC_WIDTH-1:0] iv_fifo_rdata,
    input  logic [QUEUE_NUM-1:0]            iv_gate_state,
    input  logic                            i_sched_mode,
    output logic [DESC_WIDTH-1:0]           ov_descriptor,
    output logic                            o_descriptor_wr,
    output logic [QID_WIDTH-1:0]            ov_queue_id,
    input  logic                            i_descriptor_ready,
    output logic [31:0]                     ov_desc_cnt
);

    sched_state_e         state_q, state_d;
    logic [QID_WIDTH-1:0] sel_q, sel_d;
    logic [QID_WIDTH-1:0] ptr_q, ptr_d;
    logic [31:0]          cnt_q, cnt_d;

    logic [QUEUE_NUM-1:0] elig;
    logic [QID_WIDTH-1:0] winner;
    logic                 any_valid;

    assign elig        = ~iv_fifo_empty & iv_gate_state;
    assign ov_desc_cnt = cnt_q;

    queue_select_arbiter #(
        .QUEUE_NUM (QUEUE_NUM),
        .QID_WIDTH (QID_WIDTH)
    ) u_arb (
        .elig_i      (elig),
        .ptr_i       (ptr_q),
        .mode_i      (i_sched_mode),
        .winner_o    (winner),
        .any_valid_o (any_valid)
    );

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        ptr_d           = ptr_q;
        cnt_d           = cnt_q;
        ov_fifo_rd      = '0;
        ov_descriptor   = '0;
        o_descriptor_wr = 1'b0;
        ov_queue_id     = sel_q;
        case (state_q)
            IDLE_S: begin
                if (i_descriptor_ready && any_valid) begin
                    ov_fifo_rd[winner] = 1'b1;
                    sel_d   = winner;
                    ptr_d   = (int'(winner) == QUEUE_NUM - 1) ? '0
                            : winner + QID_WIDTH'(1);
                    state_d = OUTPUT_S;
                end
            end
            OUTPUT_S: begin
                ov_descriptor   = iv_fifo_rdata[int'(sel_q)*DESC_WIDTH +: DESC_WIDTH];
                o_descriptor_wr = 1'b1;
                cnt_d           = cnt_q + 32'd1;
                state_d         = WAIT_S;
            end
            WAIT_S: begin
                if (i_descriptor_ready) begin
                    state_d = IDLE_S;
                end
            end
            default: begin
                ov_queue_id = '0;
                state_d     = IDLE_S;
            end
        endcase
        // reset aborts at once: no strobe or write escapes in the reset cycle
        if (i_rst) begin
            ov_fifo_rd      = '0;
            ov_descriptor   = '0;
            o_descriptor_wr = 1'b0;
            ov_queue_id     = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE_S;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_network_queue_scheduler.sv
// Scoreboard bench for the transmit queue scheduler.
// Directed vectors; a negedge monitor checks every descriptor write.
module tb_network_queue_scheduler;

    localparam int QN = 8;
    localparam int DW = 57;
    localparam int QW = 3;

    typedef struct {
        logic [QW-1:0] qid;
        logic [DW-1:0] d;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [QN-1:0]      emp = '1;
    logic [QN-1:0]      rd;
    logic [QN-1:0][DW-1:0] rdata_r = '0;
    logic [QN-1:0]      gate = '1;
    logic               mode = 1'b0;
    logic [DW-1:0]      desc;
    logic               wr;
    logic [QW-1:0]      qid;
    logic               ready = 1'b0;
    logic [31:0]        cnt;

    logic [DW-1:0] fq [QN][$];
    exp_t          sb [$];
    int            n_tests = 0;
    int            n_fail  = 0;

    always #5 clk = ~clk;

    network_queue_scheduler dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .iv_fifo_empty      (emp),
        .ov_fifo_rd         (rd),
        .iv_fifo_rdata      (rdata_r),
        .iv_gate_state      (gate),
        .i_sched_mode       (mode),
        .ov_descriptor      (desc),
        .o_descriptor_wr    (wr),
        .ov_queue_id        (qid),
        .i_descriptor_ready (ready),
        .ov_desc_cnt        (cnt)
    );

    function automatic logic [DW-1:0] mk(input int q, input int n);
        mk = {8'hA0 | 8'(q), 8'(n), 41'h1_2345_6789};
    endfunction

    // FIFO model: data appears the cycle after its read strobe
    always @(posedge clk) begin
        for (int q = 0; q < QN; q++) begin
            if (rd[q] && fq[q].size() > 0) begin
                rdata_r[q] <= fq[q].pop_front();
            end
            emp[q] <= (fq[q].size() == 0);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (wr) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_wr: got qid=%0d desc=%h, required no write",
                         qid, desc);
            end else begin
                e = sb.pop_front();
                n_tests += 2;
                if (qid !== e.qid) begin
                    n_fail++;
                    $display("FAIL wr_qid: got %0d, required %0d", qid, e.qid);
                end
                if (desc !== e.d) begin
                    n_fail++;
                    $display("FAIL wr_desc: got %h, required %h", desc, e.d);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push(input int q, input int n);
        exp_t e;
        fq[q].push_back(mk(q, n));
        e.qid = QW'(q);
        e.d   = mk(q, n);
    endtask

    task automatic expect_q(input int q, input int n);
        exp_t e;
        e.qid = QW'(q);
        e.d   = mk(q, n);
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_rd",   64'(rd),   64'd0);
        check("rst_wr",   64'(wr),   64'd0);
        check("rst_desc", 64'(desc), 64'd0);
        check("rst_qid",  64'(qid),  64'd0);
        check("rst_cnt",  64'(cnt),  64'd0);

        // strict priority: 7, 5, 1
        mode  = 1'b0;
        ready = 1'b1;
        push(1, 0); push(5, 0); push(7, 0);
        expect_q(7, 0); expect_q(5, 0); expect_q(1, 0);
        drain("sp_drain");
        check("sp_cnt", 64'(cnt), 64'd3);

        // gate masking: q7 closed, q2 served, then q7 after reopening
        gate = 8'h7F;
        push(7, 1); push(2, 1);
        expect_q(2, 1); expect_q(7, 1);
        k = 0;
        while (!wr && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("gate_first_wr", 64'(wr), 64'd1);
        gate = 8'hFF;
        drain("gate_drain");

        // round robin from pointer 0
        do_reset();
        mode = 1'b1;
        for (int q = 0; q < QN; q++) begin
            push(q, 2); push(q, 3);
        end
        for (int q = 0; q < QN; q++) expect_q(q, 2);
        for (int q = 0; q < QN; q++) expect_q(q, 3);
        drain("rr_drain");
        check("rr_cnt", 64'(cnt), 64'd16);

        // backpressure
        do_reset();
        mode = 1'b0;
        push(6, 4); push(6, 5);
        expect_q(6, 4); expect_q(6, 5);
        k = 0;
        while (!wr && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("bp_first_wr", 64'(wr), 64'd1);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_rd", 64'(rd), 64'd0);
            check("bp_hold_wr", 64'(wr), 64'd0);
        end
        ready = 1'b1;
        @(negedge clk);
        check("bp_rd_after", 64'(rd), 64'h40);
        @(negedge clk);
        check("bp_wr_after", 64'(wr), 64'd1);
        drain("bp_drain");

        // reset while in OUTPUT_S drops the descriptor
        push(0, 6);
        k = 0;
        while (rd == '0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("mid_rd", 64'(rd), 64'h01);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("mid_wr_gated", 64'(wr), 64'd0);
        @(negedge clk);
        check("mid_rd0",   64'(rd),   64'd0);
        check("mid_wr0",   64'(wr),   64'd0);
        check("mid_desc0", 64'(desc), 64'd0);
        check("mid_qid0",  64'(qid),  64'd0);
        check("mid_cnt0",  64'(cnt),  64'd0);
        check("mid_state", 64'(dut.state_q), 64'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_no_wr_cnt", 64'(cnt), 64'd0);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        check("wrap_pre", 64'(cnt), 64'hFFFF_FFFF);
        push(4, 7);
        expect_q(4, 7);
        drain("wrap_drain");
        check("wrap_cnt", 64'(cnt), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
